// File: rtl/cntr_pkg.sv
// Shared types and helpers for the modulo-N up/down counter family.
// Direction and mode enums plus a width-sizing helper for instantiators.
package cntr_pkg;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_HALT = 1'b1
  } cnt_mode_e;

  // Bits needed to hold 0..mod-1, never less than one.
  function automatic int cntr_width(int mod);
    int w;
    w = $clog2(mod);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cntr_tc_detect.sv
// Terminal-count detector: top of range counting up, zero counting down.
// Purely combinational; compares against constants only.
module cntr_tc_detect
  import cntr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 16
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             up,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);

  cnt_dir_e dir;

  assign dir = cnt_dir_e'(up);

  always_comb begin
    tc = 1'b0;
    unique case (dir)
      CNT_UP:   tc = (cnt == MAXV);
      CNT_DOWN: tc = (cnt == '0);
      default:  tc = 1'b0;
    endcase
  end

endmodule

// File: rtl/cntr_mod_updown.sv
// Parametrised modulo-N up/down counter with load, clear, enable,
// cascade carry and optional halt-at-terminal-count.
module cntr_mod_updown
  import cntr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 16
) (
  input  logic             clk,
  input  logic             rst_async,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             cnt_en,
  input  logic             up,
  input  logic             halt_at_tc,
  output logic [WIDTH-1:0] cnt,
  output logic             carry,
  output logic             done,
  output logic             load_err
);

  if (WIDTH < 1 || MOD < 2 ||
      longint'(MOD) > (longint'(1) << WIDTH)) begin : g_bad_mod
    $error("cntr_mod_updown: MOD must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MOD);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             tc;
  logic             in_range;
  cnt_dir_e         dir;
  cnt_mode_e        mode;

  assign dir  = cnt_dir_e'(up);
  assign mode = cnt_mode_e'(halt_at_tc);

  cntr_tc_detect #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) u_tc (
    .cnt (cnt_q),
    .up  (up),
    .tc  (tc)
  );

  assign in_range = ({1'b0, load_val} < MOD_W);

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    err_d  = 1'b0;
    if (clr) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (load) begin
      cnt_d  = in_range ? load_val : MAXV;
      err_d  = ~in_range;
      done_d = 1'b0;
    end else if (cnt_en && !done_q) begin
      if (!tc) begin
        cnt_d = (dir == CNT_UP) ? cnt_q + ONE : cnt_q - ONE;
      end else if (mode == MODE_HALT) begin
        done_d = 1'b1;
      end else begin
        // Explicit wrap keeps non-power-of-two moduli in range.
        cnt_d = (dir == CNT_UP) ? '0 : MAXV;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign cnt      = cnt_q;
  assign done     = done_q;
  assign load_err = err_q;
  assign carry    = cnt_en & tc & ~done_q;

endmodule

// File: doc/cntr_mod_updown.md
# cntr_mod_updown

Parametrised synchronous modulo-N up/down counter with parallel load, synchronous clear, count enable, terminal-count carry for cascading, and an optional halt-at-terminal mode. It generalises the team's fixed 4-bit binary counter to any width and modulus. It is the common counting primitive for timers, BCD digit chains and prescalers. Stages cascade by feeding one stage's `carry` into the next stage's `cnt_en`.

## Interface

- `WIDTH`, default 4: counter width in bits; must be ≥ 1.
- `MOD`, default 16: modulus; legal range 2..2^WIDTH; the count range is 0..MOD-1.

- `clk`  in  1  rising-edge clock
- `rst_async`  in  1  reset, asynchronous and active-high; deassertion is synchronised externally
- `clr`  in  1  synchronous clear to 0
- `load`  in  1  synchronous parallel load
- `load_val`  in  WIDTH  value to load
- `cnt_en`  in  1  count enable (cascade input)
- `up`  in  1  direction; 1 = increment, 0 = decrement
- `halt_at_tc`  in  1  mode; 0 = wrap at terminal count, 1 = stop at terminal count
- `cnt`  out  WIDTH  current count (registered)
- `carry`  out  1  `cnt_en` AND terminal count (combinational, cascade output)
- `done`  out  1  sticky flag: halted at terminal count (registered)
- `load_err`  out  1  one-cycle pulse: out-of-range load was clamped (registered)

## Operation

- Terminal count `tc` is `cnt == MOD-1` when `up`=1, and `cnt == 0` when `up`=0.
- `carry` = `cnt_en & tc & ~done`. It is combinational, so it follows `up` and `cnt_en` within the same cycle.
- Per-edge priority, highest first: `rst_async` > `clr` > `load` > count > hold.
- Reset (asynchronous, immediate): `cnt`=0, `done`=0, `load_err`=0.
- `clr`: `cnt`←0, `done`←0, `load_err`←0.
- `load`:
  - If `load_val` < MOD: `cnt`←`load_val`, `load_err`←0.
  - Otherwise: `cnt`←MOD-1, `load_err`←1 for that single cycle.
  - `done`←0 in both cases.
- Count (`cnt_en`=1, no clear or load, `done`=0):
  - Not at `tc`: `cnt` steps ±1 according to `up`.
  - At `tc` with `halt_at_tc`=0: wrap; up goes MOD-1→0, down goes 0→MOD-1.
  - At `tc` with `halt_at_tc`=1: `cnt` holds and `done`←1.
- While `done`=1, counting is frozen and `carry`=0. Only `clr`, `load` or reset releases it.
- Changing `up` while `done`=1 does not release it.
- `load_err` otherwise returns to 0 on every edge.
- Arithmetic runs at WIDTH bits. When MOD = 2^WIDTH, wrap equals natural binary overflow. Terminal-count detection uses compares against constants only; no modulo operator.
- Changing `halt_at_tc` mid-count affects only the next terminal-count event.

## Timing

- `cnt` latency: 1 clock from any control input.
- `carry` is combinational from `cnt`, `cnt_en`, `up` and `done`. No path exists from `carry` back to the same stage's `cnt_en`, so cascading forms no combinational loop.
- `done` rises on the edge where `tc` and `cnt_en` coincide in halt mode. It falls 1 clock after `clr` or `load`.
- `rst_async` takes effect mid-cycle: outputs go to reset values without waiting for `clk`.
- Simultaneous `clr` and `load`: `clr` wins.
- Simultaneous `load` and `cnt_en`: `load` wins, and no carry step is taken on that edge. `carry` may still be high combinationally during that cycle.

## Structure

- Package `cntr_pkg`:
  - `typedef enum logic {CNT_DOWN, CNT_UP}` for direction.
  - `typedef enum logic {MODE_WRAP, MODE_HALT}` for mode.
  - Helper function `cntr_width(int mod)` returning `$clog2(mod)`, minimum 1, for users sizing WIDTH.
- One sub-module, `cntr_tc_detect`, parameterised by `WIDTH` and `MOD`: a purely combinational block producing `tc` from `cnt` and `up`. The top level holds the next-state logic and registers.
- Elaboration-time assertion: 2 ≤ MOD ≤ 2^WIDTH.

## Test plan

All scenarios use WIDTH=4, MOD=10 (decade counter); asynchronous reset at t=0.

1. Reset, then `cnt_en`=1, `up`=1, wrap mode for 12 clocks:
   - `cnt` runs 0..9, 0, 1.
   - `carry`=1 only while `cnt`=9.
2. Down count: `load` 3, then `up`=0, `cnt_en`=1 for 5 clocks:
   - `cnt` runs 3, 2, 1, 0, 9, 8.
   - `carry`=1 while `cnt`=0.
3. Halt mode, up count from 7:
   - `cnt` runs 7, 8, 9 and holds at 9.
   - `done`=1 from the edge after reaching 9; `carry`=0 thereafter.
   - `load` 2 gives `done`=0 and `cnt`=2 one clock later.
4. Out-of-range `load_val`=12:
   - `cnt`=9 and `load_err`=1 for exactly one cycle.
   - `load_val`=5 gives `cnt`=5 and `load_err`=0.
5. Priority and asynchronous reset:
   - `clr` and `load`=4 on the same edge give `cnt`=0.
   - `rst_async` pulsed between edges while `cnt`=6 forces `cnt`=0 before the next edge.
6. Two instances cascaded (stage 0 `carry` → stage 1 `cnt_en`), counting up from 00 for 25 clocks:
   - Pair reads 2|5 (tens|units).
   - Stage 1 steps only on edges where stage 0 wraps 9→0.
